pipelined_control_unit: RTL

- Parametrised successor of the single-issue pipelined controller.
- Decodes RV32I control in Decode and carries it through an Execute register, a configurable-depth Memory pipe and a Writeback register.
- Resolves all six branch conditions and registers the JALR select in Execute.
- Tracks destination registers and generates load-use stall/flush internally, so the datapath hazard logic only supplies Flush_E for external causes.

---
 rtl/pipelined_control_unit.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
//
// Control path for a single-issue RV32I pipeline. It decodes the instruction
// in Decode and carries the control bits through an Execute register, a chain
// of MEM_LAT Memory registers and one Writeback register. It resolves branches
// and jumps in Execute. It also detects load-use hazards against Execute and
// every Memory stage except the last, so that it can stall Fetch/Decode itself.
//
// Parameters
//   MEM_LAT      number of Memory-stage registers (1..4)
//   REG_AW       register-address width
//   BRANCH_FULL  1: all six branch conditions; 0: BEQ/BNE only
//
// Ports
//   Clk, Reset                    clock (rising edge), async active-low reset
//   Opcode_D, Funct3_D,
//   Funct7_5_D, Rs1_D, Rs2_D,
//   Rd_D                          instruction fields in Decode
//   Zero_E, Lt_E, Ltu_E           Execute comparator flags
//   Flush_E                       external bubble request for Execute
//   ImmSrc_D, Illegal_D           Decode-stage immediate select / bad opcode
//   AluControl_E, AluSrcA_E,
//   AluSrcB_E                     Execute datapath controls
//   PCSrc_E, PCJalr_E             fetch redirect and its target select
//   Stall_FD, Flush_D             hold PC and IF/ID, or bubble IF/ID
//   MemWrite_M, Funct3_M          first Memory register (store, access size)
//   RegWrite_M, Rd_M              last Memory register (forwarding source)
//   RegWrite_W, Rd_W, ResultSrc_W Writeback stage
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
   parameter int MEM_LAT     = 1,
   parameter int REG_AW      = 5,
   parameter bit BRANCH_FULL = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [6:0]        Opcode_D,
   input  logic [2:0]        Funct3_D,
   input  logic              Funct7_5_D,
   input  logic [REG_AW-1:0] Rs1_D,
   input  logic [REG_AW-1:0] Rs2_D,
   input  logic [REG_AW-1:0] Rd_D,
   input  logic              Zero_E,
   input  logic              Lt_E,
   input  logic              Ltu_E,
   input  logic              Flush_E,
   output logic [2:0]        ImmSrc_D,
   output logic              Illegal_D,
   output logic [3:0]        AluControl_E,
   output logic              AluSrcA_E,
   output logic [1:0]        AluSrcB_E,
   output logic              PCSrc_E,
   output logic              PCJalr_E,
   output logic              Stall_FD,
   output logic              Flush_D,
   output logic              MemWrite_M,
   output logic [2:0]        Funct3_M,
   output logic              RegWrite_M,
   output logic [REG_AW-1:0] Rd_M,
   output logic              RegWrite_W,
   output logic [REG_AW-1:0] Rd_W,
   output logic [1:0]        ResultSrc_W
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [1:0] RES_MEM = 2'b01;

   typedef struct packed {
      logic              regwrite;
      logic              memwrite;
      logic              branch;
      logic              jump;
      logic              jalr;
      logic              alusrca;
      logic [1:0]        alusrcb;
      logic [1:0]        resultsrc;
      logic [3:0]        aluctrl;
      logic [2:0]        funct3;
      logic [REG_AW-1:0] rd;
   } ex_ctrl_t;

   typedef struct packed {
      logic              regwrite;
      logic              memwrite;
      logic [1:0]        resultsrc;
      logic [2:0]        funct3;
      logic [REG_AW-1:0] rd;
   } mem_ctrl_t;

   typedef struct packed {
      logic              regwrite;
      logic [1:0]        resultsrc;
      logic [REG_AW-1:0] rd;
   } wb_ctrl_t;

   // R-type and I-ALU operation from funct3/funct7[5]. SUB exists only for R-type
   // because ADDI puts immediate bits in the position of funct7[5].
   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                 input logic       f7_5,
                                                 input logic       is_r);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Branch condition. In the reduced build only funct3[2] == 0 (BEQ/BNE) can be taken.
   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic       zero,
                                         input logic       lt,
                                         input logic       ltu);
      logic t;
      case (f3)
         3'b000:  t = zero;
         3'b001:  t = ~zero;
         3'b100:  t = lt;
         3'b101:  t = ~lt;
         3'b110:  t = ltu;
         3'b111:  t = ~ltu;
         default: t = 1'b0;
      endcase
      if (!BRANCH_FULL && f3[2]) t = 1'b0;
      return t;
   endfunction

   // A stage holding a load whose destination is a source read in Decode.
   function automatic logic load_hit(input logic              regwrite,
                                     input logic [1:0]        resultsrc,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2);
      return regwrite && (resultsrc == RES_MEM) && (rd != '0) &&
             ((rd == rs1) || (rd == rs2));
   endfunction

   ex_ctrl_t  dec_ctrl;
   ex_ctrl_t  ex_d, ex_q;
   mem_ctrl_t mem_d;
   mem_ctrl_t mem_q [MEM_LAT];
   wb_ctrl_t  wb_d, wb_q;
   logic      use_funct;
   logic      load_use;
   logic      bubble_e;

   // ---------------------------------------------------------------- Decode
   always_comb begin
      dec_ctrl  = '0;
      ImmSrc_D  = 3'b000;
      Illegal_D = 1'b0;
      use_funct = 1'b0;
      case (Opcode_D)
         OP_R: begin
            dec_ctrl.regwrite = 1'b1;
            use_funct         = 1'b1;
         end
         OP_I: begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.alusrcb  = 2'b01;
            use_funct         = 1'b1;
         end
         OP_LOAD: begin
            dec_ctrl.regwrite  = 1'b1;
            dec_ctrl.alusrcb   = 2'b01;
            dec_ctrl.resultsrc = 2'b01;
         end
         OP_STORE: begin
            dec_ctrl.memwrite = 1'b1;
            dec_ctrl.alusrcb  = 2'b01;
            ImmSrc_D          = 3'b001;
         end
         OP_BRANCH: begin
            dec_ctrl.branch  = 1'b1;
            dec_ctrl.aluctrl = ALU_SUB;
            ImmSrc_D         = 3'b010;
         end
         OP_JAL: begin
            dec_ctrl.regwrite  = 1'b1;
            dec_ctrl.jump      = 1'b1;
            dec_ctrl.resultsrc = 2'b10;
            ImmSrc_D           = 3'b011;
         end
         OP_JALR: begin
            dec_ctrl.regwrite  = 1'b1;
            dec_ctrl.jump      = 1'b1;
            dec_ctrl.jalr      = 1'b1;
            dec_ctrl.alusrcb   = 2'b01;
            dec_ctrl.resultsrc = 2'b10;
         end
         OP_LUI: begin
            dec_ctrl.regwrite  = 1'b1;
            dec_ctrl.resultsrc = 2'b11;
            ImmSrc_D           = 3'b100;
         end
         OP_AUIPC: begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.alusrca  = 1'b1;
            dec_ctrl.alusrcb  = 2'b01;
            ImmSrc_D          = 3'b100;
         end
         default: Illegal_D = 1'b1;
      endcase
      if (use_funct) dec_ctrl.aluctrl = alu_from_funct(Funct3_D, Funct7_5_D, (Opcode_D == OP_R));
      dec_ctrl.funct3 = Funct3_D;
      dec_ctrl.rd     = Rd_D;
   end

   // Load-use detection: the last Memory stage already delivers its data to
   // Writeback in time for forwarding, so it is excluded.
   always_comb begin
      load_use = load_hit(ex_q.regwrite, ex_q.resultsrc, ex_q.rd, Rs1_D, Rs2_D);
      for (int i = 0; i < MEM_LAT - 1; i++) begin
         load_use = load_use |
                    load_hit(mem_q[i].regwrite, mem_q[i].resultsrc, mem_q[i].rd, Rs1_D, Rs2_D);
      end
   end

   // A redirect discards the Decode instruction anyway, so stalling it is moot.
   assign Stall_FD = load_use & ~PCSrc_E;
   assign Flush_D  = PCSrc_E;
   assign bubble_e = Flush_E | Stall_FD | PCSrc_E;
   assign ex_d     = bubble_e ? '0 : dec_ctrl;

   // ---------------------------------------------------------------- Execute
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign PCSrc_E      = (ex_q.branch & branch_taken(ex_q.funct3, Zero_E, Lt_E, Ltu_E)) | ex_q.jump;
   assign PCJalr_E     = ex_q.jump & ex_q.jalr;
   assign AluControl_E = ex_q.aluctrl;
   assign AluSrcA_E    = ex_q.alusrca;
   assign AluSrcB_E    = ex_q.alusrcb;

   assign mem_d.regwrite  = ex_q.regwrite;
   assign mem_d.memwrite  = ex_q.memwrite;
   assign mem_d.resultsrc = ex_q.resultsrc;
   assign mem_d.funct3    = ex_q.funct3;
   assign mem_d.rd        = ex_q.rd;

   // ---------------------------------------------------------------- Memory
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < MEM_LAT; i++) mem_q[i] <= '0;
      end else begin
         mem_q[0] <= mem_d;
         for (int i = 1; i < MEM_LAT; i++) mem_q[i] <= mem_q[i-1];
      end
   end

   assign MemWrite_M = mem_q[0].memwrite;
   assign Funct3_M   = mem_q[0].funct3;
   assign RegWrite_M = mem_q[MEM_LAT-1].regwrite;
   assign Rd_M       = mem_q[MEM_LAT-1].rd;

   assign wb_d.regwrite  = mem_q[MEM_LAT-1].regwrite;
   assign wb_d.resultsrc = mem_q[MEM_LAT-1].resultsrc;
   assign wb_d.rd        = mem_q[MEM_LAT-1].rd;

   // ---------------------------------------------------------------- Writeback
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) wb_q <= '0;
      else        wb_q <= wb_d;
   end

   assign RegWrite_W  = wb_q.regwrite;
   assign Rd_W        = wb_q.rd;
   assign ResultSrc_W = wb_q.resultsrc;

endmodule
